port_drain: RTL and testbench
=============================

Name: port_drain

Overview:
- Downstream stage of the port-scheduling queue. It consumes the queue's wr_data/select grant and pulls one fixed-length packet from the granted input port into a local buffer.
- It then streams the packet onto the shared output link as a header byte followed by the payload, using a valid/ready handshake.
- It drives data_empty back to the queue, which uses it to pace the next grant.

Parameters:
- DATA_W, 8: byte width of the port data buses and the output data bus; must be ≥ 2.
- PKT_LEN, 4: payload bytes per packet; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_b  in  1  reset; synchronous, active-high (rst_b=1 at a rising edge resets).
- wr_data  in  1  grant strobe from the queue; one-cycle pulse.
- select  in  2  granted port number; valid when wr_data=1.
- port_data  in  4*DATA_W  head byte of each port; port p occupies bits [p*DATA_W +: DATA_W].
- port_rd  out  4  one-hot pop to the selected port; the byte is captured on the same edge.
- out_data  out  DATA_W  output byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  the current byte is the final byte of the packet.
- data_empty  out  1  block is idle and its buffer is empty; the queue may grant.
- err_busy  out  1  one-cycle pulse when a grant arrives while the block is busy.

Behaviour:
- Reset: state=IDLE, data_empty=1, port_rd=0, out_valid=0, out_last=0, out_data=0, err_busy=0. The buffer, byte counter and latched port are cleared.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- IDLE:
  - data_empty=1.
  - wr_data=1 at edge T: latch port=select, buf[0]={DATA_W-2 zeros, select}, cnt=0, go to LOAD.
  - data_empty=0 from T+1.
- LOAD:
  - port_rd[port]=1, all other port_rd bits 0.
  - Each edge: buf[cnt+1] = port_data[port], cnt increments.
  - After the PKT_LEN-th capture: port_rd drops, cnt=0, go to SEND.
  - port_rd is therefore high for exactly PKT_LEN cycles, T+1..T+PKT_LEN.
- SEND:
  - out_valid=1, out_data=buf[cnt].
  - out_last=1 when cnt = final index, which is PKT_LEN without the optional feature.
  - A transfer occurs on an edge with out_valid & out_ready; cnt then increments.
  - out_data is held stable while out_ready=0.
  - The transfer of the out_last byte returns the block to IDLE: out_valid=0 and data_empty=1 on the next cycle.
- Minimum latency with out_ready held at 1:
  - First output byte appears at T+PKT_LEN+1.
  - data_empty returns to 1 at T+2*PKT_LEN+2.
- Grant while busy (wr_data=1 when state≠IDLE, including the final-transfer cycle):
  - The grant is ignored; no state change.
  - err_busy=1 for exactly the following cycle.
  - Back-to-back illegal grants give back-to-back pulses.
- select is ignored whenever wr_data=0. Only the latched port drives port_rd and the header.
- Counter: width $clog2(PKT_LEN+3). cnt never exceeds the final index and does not wrap.
- Reset mid-operation:
  - Takes effect at the next edge regardless of state.
  - port_rd and out_valid are 0 in the following cycle.
  - A partially loaded or partially sent packet is discarded. Bytes already popped from the port are lost; this is by design.
- out_ready arriving while not in SEND has no effect.

Optional Feature:
- Macro: PORT_DRAIN_CHKSUM_EN.
- Defined:
  - A checksum byte, the XOR of the header and all PKT_LEN payload bytes, is computed during LOAD.
  - It is stored at buf[PKT_LEN+1] and sent as an extra final byte.
  - The final index is PKT_LEN+1 and out_last moves to the checksum byte.
  - A packet is PKT_LEN+2 bytes, and the minimum data_empty return becomes T+2*PKT_LEN+3.
- Not defined: no checksum byte, no XOR logic, and the final index is PKT_LEN.

Test Plan:
- Reset then idle → data_empty=1, out_valid=0, port_rd=4'b0000 for 10 cycles.
- Grant: PKT_LEN=4, out_ready=1, port 2 bytes 0x11,0x22,0x33,0x44, wr_data pulsed with select=2 at edge T →
  - port_rd=4'b0100 at T+1..T+4.
  - out_data sequence 0x02,0x11,0x22,0x33,0x44 with out_last on 0x44.
  - data_empty=1 at T+10.
- Backpressure: same grant with out_ready low for 3 cycles starting at the 2nd SEND byte → out_data holds 0x11 for those cycles, then the sequence resumes with no byte lost or duplicated.
- Busy grant: wr_data with select=1 during LOAD of port 3 → err_busy pulses for 1 cycle, port_rd stays 4'b1000, and the header remains 0x03.
- Reset mid-SEND: rst_b=1 for 1 cycle after the 2nd transfer → next cycle out_valid=0 and data_empty=1. A new grant to port 0 then sends a correct fresh packet.
- With PORT_DRAIN_CHKSUM_EN and the port-2 bytes above → the 6th byte is 0x02^0x11^0x22^0x33^0x44 = 0x46, carries out_last, and data_empty=1 at T+11.

Source files
------------

// File: rtl/port_drain.sv
// port_drain: pulls one fixed-length packet from the granted input port into a
// local buffer, then streams it out as a header byte plus payload over a
// valid/ready link. data_empty tells the upstream queue when it may grant again.
//
// Ports:
//   clk         system clock, rising edge
//   rst_b       synchronous reset, active-high
//   wr_data     grant strobe (one-cycle pulse)
//   select      granted port number, valid with wr_data
//   port_data   head byte of each of the 4 ports, port p at [p*DATA_W +: DATA_W]
//   port_rd     one-hot pop to the latched port during LOAD
//   out_data    output byte (header, payload, optional checksum)
//   out_valid   out_data valid
//   out_ready   downstream accepts the byte
//   out_last    current byte is the final byte of the packet
//   data_empty  idle with empty buffer; queue may grant
//   err_busy    one-cycle pulse after a grant that arrived while busy
//
// Build option: define PORT_DRAIN_CHKSUM_EN to append an XOR checksum byte
// (header ^ all payload bytes) after the payload.
//
// state | meaning
// IDLE  | buffer empty, waiting for a grant
// LOAD  | popping PKT_LEN bytes from the latched port into buf[1..PKT_LEN]
// SEND  | presenting buf[cnt] on the output link until the final byte transfers

module port_drain #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wr_data,
  input  logic [1:0]            select,
  input  logic [4*DATA_W-1:0]   port_data,
  output logic [3:0]            port_rd,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  data_empty,
  output logic                  err_busy
);

  localparam int CW = $clog2(PKT_LEN + 3);
`ifdef PORT_DRAIN_CHKSUM_EN
  localparam int FINAL = PKT_LEN + 1;
`else
  localparam int FINAL = PKT_LEN;
`endif
  localparam int NBUF = FINAL + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        port_q, port_d;
  logic              err_busy_q, err_busy_d;
  logic [DATA_W-1:0] buf_q [NBUF];

  logic              hdr_we;
  logic              pay_we;
  logic [DATA_W-1:0] port_byte;
  logic [DATA_W-1:0] hdr_byte;

  assign hdr_byte = {{(DATA_W-2){1'b0}}, select};

  always_comb begin
    port_byte = port_data[DATA_W-1:0];
    case (port_q)
      2'd0: port_byte = port_data[0*DATA_W +: DATA_W];
      2'd1: port_byte = port_data[1*DATA_W +: DATA_W];
      2'd2: port_byte = port_data[2*DATA_W +: DATA_W];
      2'd3: port_byte = port_data[3*DATA_W +: DATA_W];
      default: port_byte = port_data[DATA_W-1:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    hdr_we     = 1'b0;
    pay_we     = 1'b0;
    // Any grant outside IDLE is dropped and flagged on the next cycle.
    err_busy_d = wr_data && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (wr_data) begin
          port_d  = select;
          cnt_d   = '0;
          hdr_we  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pay_we = 1'b1;
        if (cnt_q == CW'(PKT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_q == CW'(FINAL)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= '0;
      err_busy_q <= 1'b0;
      for (int i = 0; i < NBUF; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      err_busy_q <= err_busy_d;
      if (hdr_we) begin
        buf_q[0] <= hdr_byte;
`ifdef PORT_DRAIN_CHKSUM_EN
        // Running checksum seeded with the header, folded with each payload byte.
        buf_q[FINAL] <= hdr_byte;
`endif
      end
      if (pay_we) begin
        buf_q[cnt_q + CW'(1)] <= port_byte;
`ifdef PORT_DRAIN_CHKSUM_EN
        buf_q[FINAL] <= buf_q[FINAL] ^ port_byte;
`endif
      end
    end
  end

  assign data_empty = (state_q == IDLE);
  assign out_valid  = (state_q == SEND);
  assign out_last   = out_valid && (cnt_q == CW'(FINAL));
  assign out_data   = out_valid ? buf_q[cnt_q] : '0;
  assign port_rd    = (state_q == LOAD) ? (4'b0001 << port_q) : 4'b0000;
  assign err_busy   = err_busy_q;

endmodule

// File: tb/tb_port_drain.sv
module tb_port_drain;

  localparam int DATA_W  = 8;
  localparam int PKT_LEN = 4;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              wr_data;
  logic [1:0]        select;
  logic [4*DATA_W-1:0] port_data;
  logic [3:0]        port_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              data_empty;
  logic              err_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  port_drain #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .wr_data    (wr_data),
    .select     (select),
    .port_data  (port_data),
    .port_rd    (port_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .data_empty (data_empty),
    .err_busy   (err_busy)
  );

  // Port FIFO model: each port presents pmem[p][pop[p]] and advances on a pop.
  logic [7:0] pmem [4][64];
  int         pop  [4] = '{default: 0};

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (port_rd[p]) pop[p] <= pop[p] + 1;
    end
  end

  always_comb begin
    port_data = '0;
    for (int p = 0; p < 4; p++) begin
      port_data[p*8 +: 8] = pmem[p][pop[p] % 64];
    end
  end

  task automatic check(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Grant one packet and follow it cycle by cycle.
  //   stall_len   : cycles of out_ready=0 while the 2nd byte is presented
  //   busy_cnt    : illegal grants (select=1) issued on LOAD edges T+2, T+3, ...
  //   abort_after : apply reset once this many bytes have transferred (-1 = never)
  task automatic run_pkt(string tag, logic [1:0] sel,
                         logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                         int stall_len, int busy_cnt, int abort_after);
    logic [7:0] e [6];
    int         nb;
    int         pop0;
    int         idx;
    int         stall;
    int         waited;
    logic       busy_prev;
    logic [3:0] rd_exp;

    e[0] = {6'b0, sel};
    e[1] = b0; e[2] = b1; e[3] = b2; e[4] = b3;
    e[5] = 8'h00;
    nb   = 5;
`ifdef PORT_DRAIN_CHKSUM_EN
    e[5] = e[0] ^ b0 ^ b1 ^ b2 ^ b3;
    nb   = 6;
`endif
    rd_exp = 4'b0001 << sel;
    pop0   = pop[sel];
    pmem[sel][(pop0 + 0) % 64] = b0;
    pmem[sel][(pop0 + 1) % 64] = b1;
    pmem[sel][(pop0 + 2) % 64] = b2;
    pmem[sel][(pop0 + 3) % 64] = b3;

    wr_data   = 1'b1;
    select    = sel;
    out_ready = 1'b1;
    tick();
    wr_data   = 1'b0;
    select    = 2'(sel + 2'd1);
    busy_prev = 1'b0;

    for (int k = 1; k <= PKT_LEN; k++) begin
      check(tag, "load_port_rd", port_rd, rd_exp);
      check(tag, "load_empty", data_empty, 1'b0);
      check(tag, "load_valid", out_valid, 1'b0);
      check(tag, "load_err_busy", err_busy, busy_prev);
      busy_prev = (busy_cnt > 0) && (k >= 2) && (k < 2 + busy_cnt);
      wr_data   = busy_prev;
      select    = busy_prev ? 2'd1 : 2'(sel + 2'd1);
      tick();
    end
    wr_data = 1'b0;
    check(tag, "pop_count", pop[sel] - pop0, PKT_LEN);

    idx    = 0;
    stall  = stall_len;
    waited = 0;
    while (idx < nb && waited < 40) begin
      if (abort_after >= 0 && idx == abort_after) begin
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check(tag, "rst_valid", out_valid, 1'b0);
        check(tag, "rst_empty", data_empty, 1'b1);
        check(tag, "rst_port_rd", port_rd, 4'b0000);
        check(tag, "rst_data", out_data, 8'h00);
        return;
      end
      check(tag, "send_valid", out_valid, 1'b1);
      check(tag, "send_data", out_data, e[idx]);
      check(tag, "send_last", out_last, (idx == nb - 1));
      check(tag, "send_port_rd", port_rd, 4'b0000);
      check(tag, "send_empty", data_empty, 1'b0);
      check(tag, "send_err_busy", err_busy, busy_prev);
      busy_prev = 1'b0;
      if (idx == 1 && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
      tick();
      if (out_ready) idx++;
      waited++;
    end
    if (idx < nb) check(tag, "send_timeout", idx, nb);
    out_ready = 1'b1;
    check(tag, "done_valid", out_valid, 1'b0);
    check(tag, "done_empty", data_empty, 1'b1);
    check(tag, "done_last", out_last, 1'b0);
    check(tag, "done_err_busy", err_busy, 1'b0);
  endtask

  initial begin
    rst_b     = 1'b1;
    wr_data   = 1'b0;
    select    = 2'd0;
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) pmem[p][i] = 8'hEE;
    end

    repeat (3) tick();
    rst_b = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("reset", "empty", data_empty, 1'b1);
      check("reset", "valid", out_valid, 1'b0);
      check("reset", "port_rd", port_rd, 4'b0000);
      check("reset", "last", out_last, 1'b0);
      check("reset", "data", out_data, 8'h00);
      check("reset", "err_busy", err_busy, 1'b0);
      tick();
    end

    run_pkt("grant", 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, -1);
    run_pkt("bpress", 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 3, 0, -1);
    run_pkt("busy", 2'd3, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 2, -1);
    run_pkt("rst_mid", 2'd2, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 2);
    run_pkt("fresh", 2'd0, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
